mem0_issue: RTL

- Issue stage ahead of the Mem1 stage: the initiator side of the Mem0->Mem1 token interface.
- Accepts tokens from the execute stage over a valid/ready handshake and computes the 14-bit data-memory address.
- Encodes dm_dopc and mem_wen, then drives the registered Mem0/Mem1 pipeline register.
- Inserts one bubble when a load hits the address stored in the previous cycle, because DM read-after-write is not guaranteed the same cycle.

---
 rtl/mem_pkg.sv | 40 ++++
 rtl/mem0_hazard_chk.sv | 31 +++
 rtl/mem0_issue.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// mem_pkg: op encodings, widths, sideband layout and FSM states shared by the
// Mem0/Mem1 memory pipeline.
package mem_pkg;

    localparam int DATA_W = 32;
    localparam int DM_AW  = 14;
    localparam int OFS_W  = 16;
    localparam int SIDE_W = 35;

    localparam logic [1:0] OP_NONE = 2'b00;
    localparam logic [1:0] OP_ST   = 2'b01;
    localparam logic [1:0] OP_LD   = 2'b10;
    localparam logic [1:0] OP_STF  = 2'b11;

    // Sideband packing {pe_out, pe_num[2:0], f_mem_w, next_lr, next_node[15:0], gen[11:0], next_uni_opr}
    localparam int SIDE_UNI_OPR_B  = 0;
    localparam int SIDE_GEN_LSB    = 1;
    localparam int SIDE_GEN_W      = 12;
    localparam int SIDE_NODE_LSB   = 13;
    localparam int SIDE_NODE_W     = 16;
    localparam int SIDE_NEXT_LR_B  = 29;
    localparam int SIDE_F_MEM_W_B  = 30;
    localparam int SIDE_PE_NUM_LSB = 31;
    localparam int SIDE_PE_NUM_W   = 3;
    localparam int SIDE_PE_OUT_B   = 34;

    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } mem0_state_e;

    function automatic logic op_writes(input logic [1:0] op);
        return op[0];
    endfunction

    function automatic logic op_is_load(input logic [1:0] op);
        return op == OP_LD;
    endfunction

endpackage

// File: rtl/mem0_hazard_chk.sv
// mem0_hazard_chk: remembers the store currently on the Mem0 output and flags
// a load that would read that address before the write has landed.
module mem0_hazard_chk #(
    parameter int DM_AW = mem_pkg::DM_AW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_upd_st_v,
    input  logic [DM_AW-1:0] i_upd_addr,
    input  logic             i_ld_v,
    input  logic [DM_AW-1:0] i_ld_addr,
    output logic             o_hit
);

    logic             r_last_w_v;
    logic [DM_AW-1:0] r_last_w_addr;

    // Tracks whatever is loaded into the output register this cycle; bubbles clear it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_last_w_v    <= 1'b0;
            r_last_w_addr <= '0;
        end else begin
            r_last_w_v    <= i_upd_st_v;
            r_last_w_addr <= i_upd_addr;
        end
    end

    assign o_hit = i_ld_v && r_last_w_v && (i_ld_addr == r_last_w_addr);

endmodule

// File: rtl/mem0_issue.sv
// mem0_issue: Mem0 issue stage feeding the Mem1 pipeline register, with a
// one-bubble stall on load-after-store to the same address.
// Build option MEM0_ADDR_CHECK_EN adds a sticky out-of-range address check.
module mem0_issue
    import mem_pkg::*;
#(
    parameter int DATA_W = mem_pkg::DATA_W,
    parameter int DM_AW  = mem_pkg::DM_AW,
    parameter int OFS_W  = mem_pkg::OFS_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tok_valid_i_mem0,
    output logic              tok_ready_o_mem0,
    input  logic [1:0]        op_i_mem0,
    input  logic [DATA_W-1:0] opr0_i_mem0,
    input  logic [DATA_W-1:0] opr1_i_mem0,
    input  logic [OFS_W-1:0]  dm_base_i_mem0,
    input  logic [OFS_W-1:0]  dm_ofs_i_mem0,
    input  logic [SIDE_W-1:0] side_i_mem0,
    output logic              tok_valid_o_mem0,
    output logic [DATA_W-1:0] opr0_o_mem0,
    output logic [DATA_W-1:0] opr1_o_mem0,
    output logic [DM_AW-1:0]  dm_addr_o_mem0,
    output logic              mem_wen_o_mem0,
    output logic [1:0]        dm_dopc_o_mem0,
    output logic [SIDE_W-1:0] side_o_mem0,
    output logic              addr_err_o_mem0
);

`ifdef MEM0_ADDR_CHECK_EN
    localparam bit ADDR_CHK = 1'b1;
`else
    localparam bit ADDR_CHK = 1'b0;
`endif

    mem0_state_e       r_state;
    logic              r_ready;
    logic              r_valid;
    logic              r_wen;
    logic [1:0]        r_dopc;
    logic [DATA_W-1:0] r_opr0;
    logic [DATA_W-1:0] r_opr1;
    logic [DM_AW-1:0]  r_addr;
    logic [SIDE_W-1:0] r_side;
    logic              r_addr_err;

    logic [DATA_W-1:0] r_hold_opr0;
    logic [DATA_W-1:0] r_hold_opr1;
    logic [DM_AW-1:0]  r_hold_addr;
    logic [SIDE_W-1:0] r_hold_side;

    logic [OFS_W-1:0]  w_sum;
    logic [DM_AW-1:0]  w_addr;
    logic              w_oor;
    logic              w_acc;
    logic              w_ld_chk;
    logic              w_hit;
    logic              w_nxt_st_v;

    logic              w_nxt_valid;
    logic              w_nxt_wen;
    logic [1:0]        w_nxt_dopc;
    logic [DATA_W-1:0] w_nxt_opr0;
    logic [DATA_W-1:0] w_nxt_opr1;
    logic [DM_AW-1:0]  w_nxt_addr;
    logic [SIDE_W-1:0] w_nxt_side;

    assign w_sum    = dm_base_i_mem0 + dm_ofs_i_mem0;
    assign w_addr   = w_sum[DM_AW-1:0];
    assign w_oor    = ADDR_CHK && (w_sum[OFS_W-1:DM_AW] != '0);
    assign w_acc    = tok_valid_i_mem0 && r_ready && (r_state == RUN);
    // Out-of-range loads are emitted as no-ops, so they cannot collide with a store.
    assign w_ld_chk = w_acc && op_is_load(op_i_mem0) && !w_oor;

    mem0_hazard_chk #(
        .DM_AW(DM_AW)
    ) u_hazard (
        .clk        (clk),
        .rst        (rst),
        .i_upd_st_v (w_nxt_st_v),
        .i_upd_addr (w_nxt_addr),
        .i_ld_v     (w_ld_chk),
        .i_ld_addr  (w_addr),
        .o_hit      (w_hit)
    );

    always_comb begin
        w_nxt_valid = 1'b0;
        w_nxt_wen   = 1'b0;
        w_nxt_dopc  = OP_NONE;
        w_nxt_opr0  = '0;
        w_nxt_opr1  = '0;
        w_nxt_addr  = '0;
        w_nxt_side  = '0;
        if (r_state == HOLD) begin
            w_nxt_valid = 1'b1;
            w_nxt_dopc  = OP_LD;
            w_nxt_opr0  = r_hold_opr0;
            w_nxt_opr1  = r_hold_opr1;
            w_nxt_addr  = r_hold_addr;
            w_nxt_side  = r_hold_side;
        end else if (w_acc && !w_hit) begin
            w_nxt_valid = 1'b1;
            w_nxt_wen   = !w_oor && op_writes(op_i_mem0);
            w_nxt_dopc  = w_oor ? OP_NONE : op_i_mem0;
            w_nxt_opr0  = opr0_i_mem0;
            w_nxt_opr1  = opr1_i_mem0;
            w_nxt_addr  = w_addr;
            w_nxt_side  = side_i_mem0;
        end
    end

    assign w_nxt_st_v = w_nxt_valid && w_nxt_wen;

    // Output register, hold register and RUN/HOLD control share one clocked block.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= RUN;
            r_ready     <= 1'b0;
            r_valid     <= 1'b0;
            r_wen       <= 1'b0;
            r_dopc      <= OP_NONE;
            r_opr0      <= '0;
            r_opr1      <= '0;
            r_addr      <= '0;
            r_side      <= '0;
            r_addr_err  <= 1'b0;
            r_hold_opr0 <= '0;
            r_hold_opr1 <= '0;
            r_hold_addr <= '0;
            r_hold_side <= '0;
        end else begin
            r_valid <= w_nxt_valid;
            r_wen   <= w_nxt_wen;
            r_dopc  <= w_nxt_dopc;
            r_opr0  <= w_nxt_opr0;
            r_opr1  <= w_nxt_opr1;
            r_addr  <= w_nxt_addr;
            r_side  <= w_nxt_side;
            if (r_state == HOLD) begin
                r_state <= RUN;
                r_ready <= 1'b1;
            end else if (w_hit) begin
                r_state     <= HOLD;
                r_ready     <= 1'b0;
                r_hold_opr0 <= opr0_i_mem0;
                r_hold_opr1 <= opr1_i_mem0;
                r_hold_addr <= w_addr;
                r_hold_side <= side_i_mem0;
            end else begin
                r_state <= RUN;
                r_ready <= 1'b1;
            end
            if (w_acc && w_oor) begin
                r_addr_err <= 1'b1;
            end
        end
    end

    assign tok_ready_o_mem0 = r_ready;
    assign tok_valid_o_mem0 = r_valid;
    assign mem_wen_o_mem0   = r_wen;
    assign dm_dopc_o_mem0   = r_dopc;
    assign opr0_o_mem0      = r_opr0;
    assign opr1_o_mem0      = r_opr1;
    assign dm_addr_o_mem0   = r_addr;
    assign side_o_mem0      = r_side;
    assign addr_err_o_mem0  = r_addr_err;

endmodule
